// File: rtl/print_sequencer_if.sv
// Bundle of the print_sequencer job-control, character-RAM and UART-TX signals.
// The "master" modport is the sequencer's view. The "slave" modport is the
// view of the surrounding logic: trigger source, RAM and transmitter.
interface print_sequencer_if #(
  parameter int WIDTH = 64,
  parameter int DEPL2 = 4
);
  // job control
  logic             start_i;
  logic [DEPL2-1:0] base_i;
  logic [DEPL2:0]   len_i;
  logic             busy_o;
  logic             done_o;
  // character RAM
  logic [DEPL2-1:0] ram_addr_o;
  logic [WIDTH-1:0] ram_data_i;
  // UART TX byte stream
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i;

  modport master (
    input  start_i, base_i, len_i, ram_data_i, tx_ready_i,
    output ram_addr_o, tx_data_o, tx_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, base_i, len_i, ram_data_i, tx_ready_i,
    input  ram_addr_o, tx_data_o, tx_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/print_sequencer.sv
// print_sequencer: walks a range of character-RAM words and streams each word
// MSB byte first over a valid/ready byte interface toward the UART TX.
// Optional feature macro PRINT_CRLF_EN: when defined, every job ends with the
// two bytes 0x0D 0x0A before done_o pulses. This also applies to a zero-length job.
// All outputs are registers cleared asynchronously by rst_i.
module print_sequencer #(
  parameter int WIDTH = 64,
  parameter int DEPL2 = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  print_sequencer_if.master bus
);

  localparam int BYTES = WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WCW   = DEPL2 + 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [WCW-1:0] FULL_LEN  = WCW'(1) << DEPL2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
`ifdef PRINT_CRLF_EN
    ST_CR    = 3'd5,
    ST_LF    = 3'd6,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DEPL2-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]   words_left_q, words_left_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;

  // Requested lengths beyond the RAM depth still print every word exactly once.
  function automatic logic [WCW-1:0] clamp_len(input logic [WCW-1:0] len);
    if (len > FULL_LEN) begin
      return FULL_LEN;
    end else begin
      return len;
    end
  endfunction

  assign accept_s  = tx_valid_q & bus.tx_ready_i;
  assign shifted_s = sreg_q << 4'd8;

  assign bus.ram_addr_o = addr_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_valid_o = tx_valid_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

  // State and datapath registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      sreg_q       <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sreg_q       <= sreg_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic: job start, RAM fetch and latch, and byte serialisation with handshake.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sreg_d       = sreg_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          words_left_d = clamp_len(bus.len_i);
          byte_cnt_d   = '0;
          if (bus.len_i != '0) begin
            addr_d  = bus.base_i;
            state_d = ST_FETCH;
          end else begin
`ifdef PRINT_CRLF_EN
            tx_data_d  = 8'h0D;
            tx_valid_d = 1'b1;
            state_d    = ST_CR;
`else
            state_d    = ST_DONE;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // The RAM registers addr_q at the end of this cycle.
      ST_FETCH: begin
        state_d = ST_LATCH;
      end

      ST_LATCH: begin
        sreg_d     = bus.ram_data_i;
        tx_data_d  = bus.ram_data_i[WIDTH-1 -: 8];
        tx_valid_d = 1'b1;
        byte_cnt_d = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (accept_s) begin
          if (byte_cnt_q != LAST_BYTE) begin
            // Present the next byte back to back with the accepted one.
            sreg_d     = shifted_s;
            tx_data_d  = shifted_s[WIDTH-1 -: 8];
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end else begin
            byte_cnt_d   = '0;
            words_left_d = words_left_q - WCW'(1);
            if (words_left_q > WCW'(1)) begin
              // Wrap modulo the RAM depth by the natural width of the address.
              tx_valid_d = 1'b0;
              addr_d     = addr_q + DEPL2'(1);
              state_d    = ST_FETCH;
            end else begin
`ifdef PRINT_CRLF_EN
              tx_valid_d = 1'b1;
              tx_data_d  = 8'h0D;
              state_d    = ST_CR;
`else
              tx_valid_d = 1'b0;
              state_d    = ST_DONE;
`endif
            end
          end
        end else begin
          state_d = ST_SEND;
        end
      end

`ifdef PRINT_CRLF_EN
      ST_CR: begin
        if (accept_s) begin
          tx_data_d  = 8'h0A;
          tx_valid_d = 1'b1;
          state_d    = ST_LF;
        end else begin
          state_d = ST_CR;
        end
      end

      ST_LF: begin
        if (accept_s) begin
          tx_valid_d = 1'b0;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_LF;
        end
      end
`endif

      // start_i is deliberately not looked at here.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so that they are registered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_FETCH, ST_LATCH, ST_SEND: busy_d = 1'b1;
`ifdef PRINT_CRLF_EN
      ST_CR, ST_LF:                busy_d = 1'b1;
`endif
      ST_DONE:                     done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_print_sequencer.sv
// Self-checking bench for print_sequencer. A byte-queue reference model is
// built from the RAM contents, base and length. It is compared with the
// handshaked byte stream, the done timing, busy and the RAM address.
module tb_print_sequencer;
  localparam int WIDTH = 64;
  localparam int DEPL2 = 4;
  localparam int DEPTH = 16;
`ifdef PRINT_CRLF_EN
  localparam int CRLF = 1;
`else
  localparam int CRLF = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [63:0] ram_mem [DEPTH];

  always #5 clk = ~clk;

  print_sequencer_if #(.WIDTH(WIDTH), .DEPL2(DEPL2)) bus_if ();

  print_sequencer #(.WIDTH(WIDTH), .DEPL2(DEPL2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  // character RAM with one-cycle registered read
  always @(posedge clk) bus_if.ram_data_i <= ram_mem[bus_if.ram_addr_o];

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Completion cycle when tx_ready_i is high apart from 'stall' refused cycles.
  function automatic int exp_done(input int len, input int stall);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    if (n == 0) return 1 + 2 * CRLF;
    return 10 * n + 1 + 2 * CRLF + stall;
  endfunction

  // mode: 0 ready always, 1 random ready, 2 five refused cycles on byte 3.
  task automatic run_job(input string name, input int base, input int len, input int mode,
                         input int restart_cyc, input int abort_byte, input int exp_done_cyc);
    bit [7:0] exp_q[$];
    bit [7:0] got_q[$];
    logic [63:0] word;
    int n, cyc, first_valid, done_cyc, done_cnt, addr_bad, busy_bad, hold_bad, stall, acc;
    logic prev_stall;
    logic [7:0] prev_data;
    n = (len > DEPTH) ? DEPTH : len;
    for (int w = 0; w < n; w++) begin
      word = ram_mem[(base + w) % DEPTH];
      for (int b = 0; b < 8; b++) exp_q.push_back(word[63 - 8 * b -: 8]);
    end
    if (CRLF != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    first_valid = -1; done_cyc = -1; done_cnt = 0; addr_bad = 0; busy_bad = 0;
    hold_bad = 0; stall = 0; acc = 0; prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clk);
    bus_if.start_i = 1'b1;
    bus_if.base_i  = 4'(base);
    bus_if.len_i   = 5'(len);
    bus_if.tx_ready_i = 1'b1;
    cyc = 0;
    while (cyc < 3000 && (done_cyc < 0 || cyc < done_cyc + 2)) begin
      @(negedge clk);
      cyc++;
      bus_if.start_i = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        bus_if.base_i = 4'd7;
        bus_if.len_i  = 5'd3;
      end
      case (mode)
        1: bus_if.tx_ready_i = 1'($urandom_range(0, 1));
        2: begin
          if (bus_if.tx_valid_o && acc == 2 && stall < 5) begin
            bus_if.tx_ready_i = 1'b0;
            stall++;
          end else begin
            bus_if.tx_ready_i = 1'b1;
          end
        end
        default: bus_if.tx_ready_i = 1'b1;
      endcase
      if (prev_stall && (bus_if.tx_valid_o !== 1'b1 || bus_if.tx_data_o !== prev_data)) hold_bad++;
      if (bus_if.tx_valid_o && first_valid < 0) first_valid = cyc;
      if (bus_if.tx_valid_o && acc < n * 8 && bus_if.ram_addr_o !== 4'((base + acc / 8) % DEPTH))
        addr_bad++;
      if (bus_if.done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (bus_if.busy_o !== 1'b0) busy_bad++;
      end else if (done_cyc < 0 && bus_if.busy_o !== 1'b1) begin
        busy_bad++;
      end
      prev_stall = bus_if.tx_valid_o && !bus_if.tx_ready_i;
      prev_data  = bus_if.tx_data_o;
      if (bus_if.tx_valid_o && bus_if.tx_ready_i) begin
        got_q.push_back(bus_if.tx_data_o);
        acc++;
      end
      if (abort_byte >= 0 && acc == abort_byte) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check({name, " valid_after_rst"}, longint'(bus_if.tx_valid_o), 0);
        check({name, " busy_after_rst"}, longint'(bus_if.busy_o), 0);
        check({name, " done_after_rst"}, longint'(bus_if.done_o), 0);
        check({name, " addr_after_rst"}, longint'(bus_if.ram_addr_o), 0);
        return;
      end
    end
    bus_if.start_i = 1'b0;
    check({name, " byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), longint'(got_q[i]), longint'(exp_q[i]));
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " first_valid_cyc"}, first_valid, (n > 0) ? 3 : ((CRLF != 0) ? 1 : -1));
    if (exp_done_cyc >= 0) check({name, " done_cyc"}, done_cyc, exp_done_cyc);
    check({name, " addr_errors"}, addr_bad, 0);
    check({name, " busy_errors"}, busy_bad, 0);
    check({name, " hold_errors"}, hold_bad, 0);
  endtask

  initial begin
    int b, l;
    bus_if.start_i = 1'b0;
    bus_if.base_i = 4'd0;
    bus_if.len_i = 5'd0;
    bus_if.tx_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = {$urandom, $urandom};

    // reset values
    #12;
    check("rst addr", longint'(bus_if.ram_addr_o), 0);
    check("rst tx_data", longint'(bus_if.tx_data_o), 0);
    check("rst tx_valid", longint'(bus_if.tx_valid_o), 0);
    check("rst busy", longint'(bus_if.busy_o), 0);
    check("rst done", longint'(bus_if.done_o), 0);
    @(negedge clk);
    rst = 1'b0;

    ram_mem[2] = 64'h48656C6C6F210D0A;
    run_job("single", 2, 1, 0, -1, -1, exp_done(1, 0));

    ram_mem[15] = 64'h1111111111111111;
    ram_mem[0]  = 64'h2222222222222222;
    run_job("wrap", 15, 2, 0, -1, -1, exp_done(2, 0));

    run_job("backpressure", 2, 1, 2, -1, -1, exp_done(1, 5));

    ram_mem[7] = 64'hDEADBEEFCAFEF00D;
    run_job("start_busy", 2, 1, 0, 5, -1, exp_done(1, 0));

    run_job("len0", 0, 0, 0, -1, -1, exp_done(0, 0));
    run_job("len_full", 5, 16, 0, -1, -1, exp_done(16, 0));
    run_job("len_clamp", 9, 20, 0, -1, -1, exp_done(20, 0));

    run_job("abort", 2, 1, 0, -1, 3, -1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_job("after_abort", 0, 1, 0, -1, -1, exp_done(1, 0));

    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = {$urandom, $urandom};
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 20);
      run_job($sformatf("rand%0d", j), b, l, 1, -1, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/print_sequencer.md
Name: print_sequencer

Overview:
Drives the character RAM to print a message over a byte-wide serial transmit path. On a start pulse it walks a range of RAM words, reads each word with the RAM's one-cycle registered latency, and serialises each word into bytes, MSB first, on a valid/ready handshake toward the UART transmitter. It is the only master of the character RAM address bus and sits between the print trigger logic and the UART TX.

Parameters:
WIDTH, 64, RAM word width in bits; must be a multiple of 8; BYTES = WIDTH/8.
DEPL2, 4, RAM address width; RAM depth is 2**DEPL2.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle start request; ignored while busy_o=1
base_i  in  DEPL2  first RAM word address, sampled with start_i
len_i  in  DEPL2+1  number of words to print, 0..2**DEPL2, sampled with start_i
ram_addr_o  out  DEPL2  registered address to character RAM
ram_data_i  in  WIDTH  character RAM read data, valid one cycle after address
tx_data_o  out  8  byte to transmitter
tx_valid_o  out  1  tx_data_o valid
tx_ready_i  in  1  transmitter accepts byte when tx_valid_o and tx_ready_i are both 1
busy_o  out  1  high from the cycle after start is accepted until done
done_o  out  1  one-cycle pulse when the job completes

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous, active-high. All state is cleared immediately on rst_i assertion.
- Reset values: ram_addr_o=0, tx_data_o=0x00, tx_valid_o=0, busy_o=0, done_o=0, FSM=IDLE, word and byte counters=0.
- FSM states: IDLE, FETCH, LATCH, SEND, DONE (plus CR and LF when the optional feature is enabled).
- IDLE: when start_i=1, latch base_i and len_i.
  - If len_i>0: ram_addr_o<=base_i, go to FETCH.
  - If len_i=0: go to DONE. No bytes are sent unless the optional feature is enabled.
- FETCH: one cycle; the RAM samples ram_addr_o. Go to LATCH.
- LATCH: ram_data_i is valid. Capture it into a WIDTH-bit shift register. Set tx_data_o to ram_data_i[WIDTH-1:WIDTH-8] and tx_valid_o to 1. Go to SEND.
- Latency: with start_i sampled high in cycle 0, FETCH is cycle 1, LATCH is cycle 2, and tx_valid_o is first high in cycle 3.
- SEND handshake:
  - tx_data_o and tx_valid_o hold stable while tx_valid_o=1 and tx_ready_i=0.
  - On acceptance with bytes remaining in the word: shift left 8 bits and present the next byte in the next cycle, with no bubble.
  - On acceptance of the last byte (BYTES-th) of the word:
    - If more words remain: tx_valid_o<=0, ram_addr_o<=ram_addr_o+1, go to FETCH. This gives a 2-cycle bubble between words.
    - Otherwise: tx_valid_o<=0, go to DONE.
- Address arithmetic: ram_addr_o increments modulo 2**DEPL2, so a range wraps past the top address to 0. len_i=2**DEPL2 prints every word exactly once.
- DONE: one cycle. done_o=1 and busy_o=0 in this cycle, then go to IDLE. done_o is therefore high in the cycle after the final byte handshake.
- busy_o: 1 in FETCH, LATCH, SEND, CR and LF; 0 in IDLE and DONE.
- A start_i that arrives in DONE is ignored. A start_i that arrives in IDLE is accepted.
- len_i values greater than 2**DEPL2 are clamped to 2**DEPL2.
- Reset mid-job: tx_valid_o drops asynchronously and the partial message is abandoned. No done_o pulse is produced.
- The block does not drive the RAM's own reset.

Optional Feature:
PRINT_CRLF_EN
- Defined: after the last byte of the last word is accepted, the FSM goes to CR and presents 0x0D, then to LF and presents 0x0A, each using the same valid/ready handshake. The byte stream continues with no bubble. DONE follows acceptance of 0x0A. For len_i=0, the job sends only 0x0D 0x0A.
- Not defined: the CR and LF states are absent, and the job ends after the last RAM byte.

Test Plan:
- Single word: RAM[2]=0x48656C6C6F210D0A, base_i=2, len_i=1, tx_ready_i tied 1 -> bytes 48 65 6C 6C 6F 21 0D 0A on cycles 3..10; done_o pulses in cycle 11; ram_addr_o=2 throughout.
- Wrap-around: base_i=15, len_i=2, RAM[15]=0x1111111111111111, RAM[0]=0x2222222222222222 -> eight 0x11 bytes, 2-cycle bubble, eight 0x22 bytes; ram_addr_o goes 15 then 0.
- Backpressure: tx_ready_i low for 5 cycles during byte 3 -> tx_data_o holds 0x6C and tx_valid_o stays 1 until ready; the full sequence is otherwise unchanged.
- Start while busy: a second start_i with base_i=7 in cycle 5 -> ignored; output identical to the first job; exactly one done_o pulse.
- Async reset mid-job: assert rst_i between clock edges during byte 4 -> tx_valid_o, busy_o and done_o are 0 immediately; after release, a new start_i with base_i=0, len_i=1 prints RAM[0] correctly.
- len_i=0: -> done_o pulses in cycle 1 and no tx_valid_o. With PRINT_CRLF_EN defined, 0D then 0A are sent, followed by done_o.
